// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / PC stage: FETCH issues an imem request and latches the word, EXEC pulses enable and commits next_pc.
// Optional macro FETCH_ALIGN_CHECK_EN: force committed PC to word alignment and raise a sticky align_err.
module fetch_pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             enable,
  input  logic [1:0]       pcsel,
  input  logic [31:0]      signimm,
  input  logic [31:0]      rs_data,
  input  logic             stall,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired,
  output logic             align_err
);

  typedef enum logic [0:0] {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        commit;
  logic [31:0] next_pc;
  logic [31:0] pc_commit;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Outputs are gated by reset so nothing leaks out on the reset cycle itself.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    commit    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = ~reset;
        if (imem_ack) state_nxt = EXEC;
      end
      EXEC: begin
        commit = ~stall;
        if (!stall) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign enable    = commit & ~reset;
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (pcsel)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc_plus4 + (signimm << 2);
      2'b10: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b11: next_pc = rs_data;
      default: next_pc = pc_plus4;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_commit = {next_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset)                                align_err <= 1'b0;
    else if (commit && (next_pc[1:0] != 2'b00)) align_err <= 1'b1;
  end
`else
  assign pc_commit = next_pc;
  assign align_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= PC_RESET;
      instr   <= 32'h0;
      retired <= '0;
    end else begin
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (commit) begin
        pc      <= pc_commit;
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and program-counter stage. It sits directly upstream of the instruction decoder/controller.
- Holds the PC and issues a request/acknowledge fetch to instruction memory.
- Latches the returned instruction and presents its op/func fields to the controller.
- Produces the controller's `enable` as a one-cycle execute pulse per instruction.
- Consumes the controller's `pcsel`, plus datapath-supplied immediate and register values, to form the next PC.

Parameters:
- PC_RESET, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  instruction memory response valid; sampled only in FETCH.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr  out  32  latched instruction; op=instr[31:26], func=instr[5:0] go to controller.
- enable  out  1  execute pulse to controller (gates werf/wr).
- pcsel  in  2  from controller: 00 pc+4, 01 branch, 10 jump, 11 register jump.
- signimm  in  32  sign-extended immediate from datapath.
- rs_data  in  32  register-file rs read value (JR/JALR target).
- stall  in  1  external hold; freezes the stage in EXEC while high.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4 (JAL/JALR link value).
- retired  out  CNT_W  count of executed instructions.
- align_err  out  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high; takes priority over every other input, in any state including mid-fetch):
  - pc=PC_RESET, instr=32'h0, retired=0, align_err=0, state=FETCH.
  - While reset is high: imem_req=0, enable=0.
  - Any imem_ack arriving during reset is discarded.
- States: FETCH, EXEC. Two-bit or one-hot encoding is allowed; no other states.
- FETCH:
  - imem_req=1, enable=0.
  - On imem_ack=1: instr<=imem_rdata, go to EXEC.
  - imem_ack=0: stay, holding imem_addr stable.
  - Memory latency is unbounded.
- EXEC:
  - imem_req=0, enable=1 (combinational from state, and not stall).
  - stall=1: stay in EXEC, enable=0, no PC/counter update.
  - stall=0: pc<=next_pc, retired<=retired+1, go to FETCH.
  - Exactly one enable cycle per instruction.
- imem_ack outside FETCH is ignored and leaves no state effect.
- next_pc by pcsel:
  - 00: pc+4.
  - 01: pc+4 + (signimm<<2), mod 2^32.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: rs_data.
- Arithmetic wraps modulo 2^32: pc=32'hFFFF_FFFC with pcsel=00 gives 32'h0.
- pc_plus4 = pc+4, combinational.
- retired wraps to 0 past all-ones.
- Throughput: minimum 2 cycles per instruction (ack in the first FETCH cycle).
- pcsel/signimm/rs_data are sampled only on the EXEC cycle with stall=0.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - If next_pc[1:0]!=0 when leaving EXEC, pc<={next_pc[31:2],2'b00} and align_err<=1.
  - align_err is sticky until reset.
  - Branch and jump targets are always aligned, so only pcsel=11 can trigger it.
- Undefined:
  - pc<=next_pc unmodified.
  - align_err tied to 0.
  - No extra logic.

Test Plan:
- Reset → pc=32'h0040_0000, imem_req=0, enable=0, retired=0. After reset falls: imem_req=1, imem_addr=32'h0040_0000.
- imem_ack after 3 wait cycles with rdata=32'h2008_0005, pcsel=00 → instr=32'h2008_0005, enable high for exactly 1 cycle, then pc=32'h0040_0004, retired=1.
- At pc=32'h0040_0008: BEQ taken, pcsel=01, signimm=32'hFFFF_FFFF → next pc=32'h0040_0008. Then pcsel=10 with instr[25:0]=26'h010_0003 → pc=32'h0040_000C.
- In EXEC, stall=1 for 4 cycles → enable=0, pc and retired unchanged. Release → single enable cycle, single pc update.
- pcsel=11, rs_data=32'h0040_0021:
  - With FETCH_ALIGN_CHECK_EN: pc=32'h0040_0020, align_err=1 until reset.
  - Without it: pc=32'h0040_0021, align_err=0.
- reset asserted mid-FETCH while imem_ack=1 → instr stays 32'h0, pc=PC_RESET. Fetch restarts cleanly after reset falls.
